pass_gate_pipe: RTL and testbench

Parametrised, pipelined successor of the single-bit inhibit ("pass") gate: applies a selectable bitwise two-input function (default f = ~x & y) across WIDTH channels. Each transfer carries its own mode, so one operation is selectable per transfer. Results are registered behind a valid/ready handshake, and an optional saturating counter tracks non-zero results. The block sits between the input-capture logic and the output mux of the TT03 mmm design.

---
 rtl/pass_gate_pipe.sv | 116 +++++++++++
 tb/tb_pass_gate_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pass_gate_pipe.sv
// Registered bitwise two-input gate array with per-transfer function select and valid/ready output.
// Optional non-zero result counter is built when PASS_GATE_CNT_EN is defined.

module pass_gate_lane (
    input  logic [2:0] mode,
    input  logic       x,
    input  logic       y,
    output logic       f
);
    always_comb begin
        f = 1'b0;
        case (mode)
            3'd0: f = ~x & y;
            3'd1: f = x & y;
            3'd2: f = x | y;
            3'd3: f = x ^ y;
            3'd4: f = ~(x & y);
            3'd5: f = ~(x | y);
            3'd6: f = ~(x ^ y);
            3'd7: f = x & ~y;
            default: f = 1'b0;
        endcase
    end
endmodule

module pass_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             f_any,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] pass_cnt
);
    logic [WIDTH-1:0] op_res;
    logic             accept, xfer;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             f_any_q, f_any_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pass_gate_lane u_lane (
            .mode (mode),
            .x    (x[i]),
            .y    (y[i]),
            .f    (op_res[i])
        );
    end

    // A held result frees the slot in the same cycle it is taken downstream.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        f_any_d     = f_any_q;
        if (accept) begin
            out_valid_d = 1'b1;
            f_d         = op_res;
            f_any_d     = |op_res;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            f_any_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            f_any_q     <= f_any_d;
        end
    end

    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign f_any     = f_any_q;

`ifdef PASS_GATE_CNT_EN
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;

    // Clear wins over a counting transfer; count sticks at all-ones.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        if (clr_cnt)
            pass_cnt_d = '0;
        else if (xfer && f_any_q && (pass_cnt_q != {CNT_W{1'b1}}))
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pass_cnt_q <= '0;
        else        pass_cnt_q <= pass_cnt_d;
    end

    assign pass_cnt = pass_cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign pass_cnt   = '0;
`endif
endmodule

// File: tb/tb_pass_gate_pipe.sv
// Scoreboard bench for pass_gate_pipe: driver pushes truth-table results, monitor pops on transfer.
module tb_pass_gate_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PASS_GATE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    // Truth table per mode, indexed by {x,y}.
    localparam bit [3:0] TT [8] = '{4'b0010, 4'b1000, 4'b1110, 4'b0110,
                                    4'b0111, 4'b0001, 4'b1001, 4'b0100};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, in_ready;
    logic [WIDTH-1:0] x = '0, y = '0;
    logic [2:0]       mode = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [WIDTH-1:0] f;
    logic             f_any;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] pass_cnt;

    typedef struct { logic [WIDTH-1:0] f; logic any; } exp_t;
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cnt_m = 0;
    bit   acc_now = 1'b0;

    pass_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .f_any(f_any), .clr_cnt(clr_cnt), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        bit [3:0] tt;
        tt = TT[m];
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit iv, input logic [2:0] m, input logic [WIDTH-1:0] xx,
                       input logic [WIDTH-1:0] yy, input bit ordy, input bit clr);
        exp_t e;
        bit   rdy;
        @(negedge clk);
        in_valid = iv; mode = m; x = xx; y = yy; out_ready = ordy; clr_cnt = clr;
        acc_now = 1'b0;
        #1;
        rdy = (q.size() == 0) || ordy;
        chk("in_ready", in_ready, rdy);
        if (iv && rdy) begin
            e.f = ref_op(m, xx, yy);
            e.any = (e.f != '0);
            q.push_back(e);
            acc_now = 1'b1;
        end
    endtask

    // Monitor: compares presented output, pops on transfer, advances counter model.
    initial begin
        exp_t e;
        bit   cnt_hit;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("out_valid", out_valid, (q.size() - int'(acc_now)) > 0);
                chk("pass_cnt", pass_cnt, cnt_m);
                cnt_hit = 1'b0;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_output: f=%0h with empty scoreboard", f);
                    end else begin
                        e = q[0];
                        chk("f", f, e.f);
                        chk("f_any", f_any, e.any);
                        if (out_ready) begin
                            void'(q.pop_front());
                            cnt_hit = e.any;
                        end
                    end
                end
                if (CNT_ON) begin
                    if (clr_cnt) cnt_m = 0;
                    else if (cnt_hit && cnt_m < CMAX) cnt_m++;
                end
            end
        end
    end

    initial begin
        // Power-on reset
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_f", f, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); #3 rst_n = 1'b1;

        // Mode sweep
        for (int m = 0; m < 8; m++) cyc(1, 3'(m), 8'hCC, 8'hAA, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Backpressure: hold 0F while stalled, then accept on release
        cyc(1, 0, 8'h00, 8'h0F, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 3'd3, 8'h5A, 8'hFF, 0, 0);
        cyc(1, 3'd3, 8'h5A, 8'hFF, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Streaming, 16 back-to-back
        for (int i = 0; i < 16; i++)
            cyc(1, 3'($urandom_range(7)), WIDTH'($urandom), WIDTH'($urandom), 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Saturation: 20 non-zero results
        for (int i = 0; i < 20; i++) cyc(1, 3'd2, WIDTH'($urandom_range(255, 1)), 8'h00, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("sat_cnt", pass_cnt, CNT_ON ? CMAX : 0);
        // Clear coinciding with a counting transfer
        cyc(1, 3'd2, 8'h01, 8'h00, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("clr_cnt", pass_cnt, 0);
        // Zero results do not count
        for (int i = 0; i < 5; i++) cyc(1, 3'd1, 8'h00, WIDTH'($urandom), 1, 0);
        cyc(1, 3'd2, 8'h80, 8'h00, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("zero_nocount", pass_cnt, CNT_ON ? 1 : 0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(1)), 3'($urandom_range(7)), WIDTH'($urandom), WIDTH'($urandom),
                1'($urandom_range(3) != 0), 1'($urandom_range(31) == 0));

        // Reset mid-stream with a stalled FF result
        cyc(1, 3'd2, 8'hFF, 8'h00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk); #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_f", f, 0);
        chk("mid_rst_f_any", f_any, 0);
        chk("mid_rst_cnt", pass_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        cnt_m = 0;
        @(negedge clk); #3 rst_n = 1'b1;
        cyc(1, 3'd0, 8'h0F, 8'hF0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Drain
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
